// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared widths, entry record and helpers for the ALU reservation
//            station slice.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ROBID_W      = 4;
  localparam int DATA_W       = 8;
  localparam int NSRC         = 2;
  // flags bit that marks the immediate form: source 1 is carried in depval[1]
  localparam int IMM_FLAG_BIT = 2;

  typedef struct packed {
    logic [DATA_W-1:0]             operand;
    logic [DATA_W-1:0]             flags;
    logic [DATA_W-1:0]             wbs;
    logic [ROBID_W-1:0]            robid;
    logic [NSRC-1:0][ROBID_W-1:0]  deptag;
    logic [NSRC-1:0][DATA_W-1:0]   depval;
    logic [NSRC-1:0]               depready;
    logic                          valid;
  } rs_entry_t;

  // True when the current CDB broadcast carries the value a source waits on
  function automatic logic cdb_hit(input logic               cdb_valid,
                                   input logic [ROBID_W-1:0] cdb_id,
                                   input logic [ROBID_W-1:0] tag);
    return cdb_valid && (cdb_id == tag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_if
// Purpose  : Dispatch, CDB snoop, flush/stall and issue signals of the ALU
//            reservation station. master = core side, slave = the station.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rs_if;
  import alu_pkg::*;

  logic                          flush;
  logic                          dispatch_valid;
  logic [DATA_W-1:0]             dispatch_operand;
  logic [DATA_W-1:0]             dispatch_flags;
  logic [DATA_W-1:0]             dispatch_wbs;
  logic [ROBID_W-1:0]            dispatch_robid;
  logic [NSRC-1:0]               dispatch_depready;
  logic [NSRC-1:0][ROBID_W-1:0]  dispatch_deptag;
  logic [NSRC-1:0][DATA_W-1:0]   dispatch_depval;
  logic                          rs_full;
  logic                          cdb_valid;
  logic [ROBID_W-1:0]            cdb_id;
  logic [DATA_W-1:0]             cdb_val;
  logic                          fu_busy;
  logic                          issue_transmit;
  logic [DATA_W-1:0]             issue_operand;
  logic [DATA_W-1:0]             issue_flags;
  logic [DATA_W-1:0]             issue_wbs;
  logic [NSRC-1:0][DATA_W-1:0]   issue_depvals;
  logic [ROBID_W-1:0]            issue_robid;

  modport master (
    output flush, dispatch_valid, dispatch_operand, dispatch_flags,
           dispatch_wbs, dispatch_robid, dispatch_depready, dispatch_deptag,
           dispatch_depval, cdb_valid, cdb_id, cdb_val, fu_busy,
    input  rs_full, issue_transmit, issue_operand, issue_flags, issue_wbs,
           issue_depvals, issue_robid
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_operand, dispatch_flags,
           dispatch_wbs, dispatch_robid, dispatch_depready, dispatch_deptag,
           dispatch_depval, cdb_valid, cdb_id, cdb_val, fu_busy,
    output rs_full, issue_transmit, issue_operand, issue_flags, issue_wbs,
           issue_depvals, issue_robid
  );

endinterface
`default_nettype wire

// File: rtl/alu_rs_select.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_select
// Purpose  : Oldest-ready picker. older[j][i]=1 means entry j was dispatched
//            before entry i. An entry is granted when it is ready and no
//            other ready entry is older than it. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
    logic [DEPTH-1:0] w_older_than_me;

    // Column gi of the age matrix, with the diagonal forced off
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
      assign w_older_than_me[gj] = (gi != gj) ? older[gj][gi] : 1'b0;
    end

    assign grant[gi] = ready[gi] & ~(|(ready & w_older_than_me));
  end

endmodule
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Purpose  : ALU reservation station. Holds DEPTH dispatched instructions,
//            snoops the CDB for missing sources (including the instruction
//            being dispatched), and issues the oldest ready entry to the ALU
//            with a registered one-cycle strobe and at least one idle cycle
//            between issues.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rs
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  alu_rs_if.slave bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rs_entry_t                   r_entry [DEPTH];
  rs_entry_t                   w_entry_next [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] r_older;
  logic [DEPTH-1:0][DEPTH-1:0] w_older_next;

  logic                        r_transmit;
  logic [DATA_W-1:0]           r_operand;
  logic [DATA_W-1:0]           r_flags;
  logic [DATA_W-1:0]           r_wbs;
  logic [NSRC-1:0][DATA_W-1:0] r_depvals;
  logic [ROBID_W-1:0]          r_robid;

  rs_entry_t                   w_new_entry;
  rs_entry_t                   w_sel_entry;
  logic [DEPTH-1:0]            w_valid;
  logic [DEPTH-1:0]            w_ready;
  logic [DEPTH-1:0]            w_alloc;
  logic [DEPTH-1:0]            w_grant;
  logic                        w_full;
  logic                        w_accept;
  logic                        w_issue;

  // Per-entry occupancy and readiness taken from registered state only
  always_comb begin
    w_valid = '0;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_entry[i].valid;
      w_ready[i] = r_entry[i].valid & (&r_entry[i].depready);
    end
  end

  // Full only from current occupancy; a same-cycle issue does not make room
  assign w_full   = &w_valid;
  // Lowest-index free slot: isolate the lowest zero bit of the valid vector
  assign w_alloc  = ~w_valid & (w_valid + DEPTH'(1));
  assign w_accept = bus.dispatch_valid & ~w_full & ~bus.flush;
  // Issue only from idle strobe so back-to-back issues are separated by a gap
  assign w_issue  = ~bus.fu_busy & ~r_transmit & (|w_ready);

  alu_rs_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .ready (w_ready),
    .older (r_older),
    .grant (w_grant)
  );

  // Build the incoming entry, folding in immediate form and same-cycle CDB hit
  always_comb begin
    w_new_entry          = '0;
    w_new_entry.operand  = bus.dispatch_operand;
    w_new_entry.flags    = bus.dispatch_flags;
    w_new_entry.wbs      = bus.dispatch_wbs;
    w_new_entry.robid    = bus.dispatch_robid;
    w_new_entry.valid    = 1'b1;
    for (int s = 0; s < NSRC; s++) begin
      w_new_entry.deptag[s]   = bus.dispatch_deptag[s];
      w_new_entry.depval[s]   = bus.dispatch_depval[s];
      w_new_entry.depready[s] = bus.dispatch_depready[s];
    end
    if (bus.dispatch_flags[IMM_FLAG_BIT]) begin
      w_new_entry.depready[1] = 1'b1;
    end
    for (int s = 0; s < NSRC; s++) begin
      if (!w_new_entry.depready[s] &&
          cdb_hit(bus.cdb_valid, bus.cdb_id, w_new_entry.deptag[s])) begin
        w_new_entry.depready[s] = 1'b1;
        w_new_entry.depval[s]   = bus.cdb_val;
      end
    end
  end

  // Next entry state: wake-up, free on issue, allocate, then flush wins
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_next[i] = r_entry[i];
      if (r_entry[i].valid) begin
        for (int s = 0; s < NSRC; s++) begin
          if (!r_entry[i].depready[s] &&
              cdb_hit(bus.cdb_valid, bus.cdb_id, r_entry[i].deptag[s])) begin
            w_entry_next[i].depready[s] = 1'b1;
            w_entry_next[i].depval[s]   = bus.cdb_val;
          end
        end
      end
      if (w_issue && w_grant[i]) begin
        w_entry_next[i].valid = 1'b0;
      end
      if (w_accept && w_alloc[i]) begin
        w_entry_next[i] = w_new_entry;
      end
      if (bus.flush) begin
        w_entry_next[i].valid = 1'b0;
      end
    end
  end

  // Age matrix update: a new entry is younger than every currently held one
  always_comb begin
    w_older_next = r_older;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (w_accept && w_alloc[i]) begin
          w_older_next[i][j] = 1'b0;
        end else if (w_accept && w_alloc[j]) begin
          w_older_next[i][j] = w_valid[i];
        end
      end
    end
  end

  // Mux out the granted entry for the issue registers
  always_comb begin
    w_sel_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_sel_entry = r_entry[i];
      end
    end
  end

  // Entry storage and age state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
      r_older <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= w_entry_next[i];
      end
      r_older <= w_older_next;
    end
  end

  // Issue strobe and payload; payload holds its last value between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_transmit <= 1'b0;
      r_operand  <= '0;
      r_flags    <= '0;
      r_wbs      <= '0;
      r_depvals  <= '0;
      r_robid    <= '0;
    end else if (bus.flush) begin
      r_transmit <= 1'b0;
    end else if (w_issue) begin
      r_transmit <= 1'b1;
      r_operand  <= w_sel_entry.operand;
      r_flags    <= w_sel_entry.flags;
      r_wbs      <= w_sel_entry.wbs;
      r_depvals  <= w_sel_entry.depval;
      r_robid    <= w_sel_entry.robid;
    end else begin
      r_transmit <= 1'b0;
    end
  end

  assign bus.rs_full        = w_full;
  assign bus.issue_transmit = r_transmit;
  assign bus.issue_operand  = r_operand;
  assign bus.issue_flags    = r_flags;
  assign bus.issue_wbs      = r_wbs;
  assign bus.issue_depvals  = r_depvals;
  assign bus.issue_robid    = r_robid;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Purpose  : Self-checking bench for alu_rs with an issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs;
  import alu_pkg::*;

  typedef struct {
    logic [3:0] robid;
    logic [7:0] operand;
    logic [7:0] flags;
    logic [7:0] wbs;
    logic [7:0] dv0;
    logic [7:0] dv1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  alu_rs_if bus ();

  alu_rs #(
    .DEPTH (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dispatch(input logic [3:0] robid, input logic [7:0] op,
                              input logic [7:0] flags, input logic [1:0] rdy,
                              input logic [3:0] t0, input logic [3:0] t1,
                              input logic [7:0] v0, input logic [7:0] v1);
    bus.dispatch_valid      = 1'b1;
    bus.dispatch_robid      = robid;
    bus.dispatch_operand    = op;
    bus.dispatch_flags      = flags;
    bus.dispatch_wbs        = {4'h4, robid};
    bus.dispatch_depready   = rdy;
    bus.dispatch_deptag[0]  = t0;
    bus.dispatch_deptag[1]  = t1;
    bus.dispatch_depval[0]  = v0;
    bus.dispatch_depval[1]  = v1;
  endtask

  task automatic dispatch(input logic [3:0] robid, input logic [7:0] op,
                          input logic [7:0] flags, input logic [1:0] rdy,
                          input logic [3:0] t0, input logic [3:0] t1,
                          input logic [7:0] v0, input logic [7:0] v1);
    set_dispatch(robid, op, flags, rdy, t0, t1, v0, v1);
    tick();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] robid, input logic [7:0] op,
                      input logic [7:0] flags, input logic [7:0] v0, input logic [7:0] v1);
    exp_t e;
    e.robid   = robid;
    e.operand = op;
    e.flags   = flags;
    e.wbs     = {4'h4, robid};
    e.dv0     = v0;
    e.dv1     = v1;
    sb_q.push_back(e);
  endtask

  task automatic cdb(input logic v, input logic [3:0] id, input logic [7:0] val);
    bus.cdb_valid = v;
    bus.cdb_id    = id;
    bus.cdb_val   = val;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rs_full"},  32'(bus.rs_full), 32'd0);
    check({tag, "_transmit"}, 32'(bus.issue_transmit), 32'd0);
    check({tag, "_robid"},    32'(bus.issue_robid), 32'd0);
    check({tag, "_operand"},  32'(bus.issue_operand), 32'd0);
    check({tag, "_depvals"},  32'(bus.issue_depvals), 32'd0);
    check({tag, "_wbs"},      32'(bus.issue_wbs), 32'd0);
  endtask

  // Scoreboard: every issue strobe must match the next expected instruction
  always @(negedge clk) begin
    if (!rst && bus.issue_transmit) begin
      if (sb_q.size() == 0) begin
        check("unexpected_issue_robid", 32'(bus.issue_robid), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("iss_robid",   32'(bus.issue_robid),      32'(e.robid));
        check("iss_operand", 32'(bus.issue_operand),    32'(e.operand));
        check("iss_flags",   32'(bus.issue_flags),      32'(e.flags));
        check("iss_wbs",     32'(bus.issue_wbs),        32'(e.wbs));
        check("iss_dv0",     32'(bus.issue_depvals[0]), 32'(e.dv0));
        check("iss_dv1",     32'(bus.issue_depvals[1]), 32'(e.dv1));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.flush             = 1'b0;
    bus.dispatch_valid    = 1'b0;
    bus.dispatch_operand  = '0;
    bus.dispatch_flags    = '0;
    bus.dispatch_wbs      = '0;
    bus.dispatch_robid    = '0;
    bus.dispatch_depready = '0;
    bus.dispatch_deptag   = '0;
    bus.dispatch_depval   = '0;
    bus.fu_busy           = 1'b0;
    cdb(1'b0, 4'h0, 8'h00);

    // Reset state
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post_reset_idle", 32'(bus.issue_transmit), 32'd0);

    // ADD, both sources ready
    push(4'd1, 8'h01, 8'h00, 8'h12, 8'h34);
    dispatch(4'd1, 8'h01, 8'h00, 2'b11, 4'h0, 4'h0, 8'h12, 8'h34);
    check("add_not_early", 32'(bus.issue_transmit), 32'd0);
    tick();
    check("add_issue", 32'(bus.issue_transmit), 32'd1);
    check("add_dv0", 32'(bus.issue_depvals[0]), 32'h12);
    check("add_dv1", 32'(bus.issue_depvals[1]), 32'h34);
    tick();
    check("add_one_cycle", 32'(bus.issue_transmit), 32'd0);
    check("add_payload_hold", 32'(bus.issue_robid), 32'd1);

    // Source 0 waits on tag 5, broadcast two cycles later
    push(4'd2, 8'h02, 8'h00, 8'hA5, 8'h22);
    dispatch(4'd2, 8'h02, 8'h00, 2'b10, 4'h5, 4'h0, 8'h00, 8'h22);
    check("wake_wait0", 32'(bus.issue_transmit), 32'd0);
    tick();
    check("wake_wait1", 32'(bus.issue_transmit), 32'd0);
    cdb(1'b1, 4'h5, 8'hA5);
    tick();
    cdb(1'b0, 4'h0, 8'h00);
    check("wake_wait2", 32'(bus.issue_transmit), 32'd0);
    tick();
    check("wake_issue", 32'(bus.issue_transmit), 32'd1);

    // Broadcast in the same cycle as dispatch
    push(4'd3, 8'h03, 8'h00, 8'h11, 8'h7F);
    cdb(1'b1, 4'h3, 8'h7F);
    dispatch(4'd3, 8'h03, 8'h00, 2'b01, 4'h0, 4'h3, 8'h11, 8'h00);
    cdb(1'b0, 4'h0, 8'h00);
    tick();
    check("bypass_issue", 32'(bus.issue_transmit), 32'd1);
    check("bypass_dv1", 32'(bus.issue_depvals[1]), 32'h7F);

    // Immediate form: source 1 ready despite depready[1]=0
    push(4'd4, 8'h04, 8'h04, 8'h21, 8'h55);
    dispatch(4'd4, 8'h04, 8'h04, 2'b01, 4'h0, 4'h9, 8'h21, 8'h55);
    tick();
    check("imm_issue", 32'(bus.issue_transmit), 32'd1);
    tick();

    // Fill with FU busy, fifth dispatch refused, then ordered drain
    bus.fu_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(4'(8 + k), 8'(8'h80 + k), 8'h00, 8'(8'hB0 + k), 8'(8'hC0 + k));
      dispatch(4'(8 + k), 8'(8'h80 + k), 8'h00, 2'b11, 4'h0, 4'h0,
               8'(8'hB0 + k), 8'(8'hC0 + k));
    end
    check("full_set", 32'(bus.rs_full), 32'd1);
    dispatch(4'd12, 8'h8C, 8'h00, 2'b11, 4'h0, 4'h0, 8'hEE, 8'hEE);
    check("full_hold", 32'(bus.rs_full), 32'd1);
    check("full_busy_no_issue", 32'(bus.issue_transmit), 32'd0);
    bus.fu_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("full_strobe", 32'(bus.issue_transmit), 32'((k % 2) == 0));
      if (k == 0) check("full_cleared", 32'(bus.rs_full), 32'd0);
    end
    repeat (3) begin
      tick();
      check("full_fifth_dropped", 32'(bus.issue_transmit), 32'd0);
    end
    check("full_drained", 32'(sb_q.size()), 32'd0);

    // Age ordering: younger-ready first, then oldest of two ready
    push(4'd5, 8'h05, 8'h00, 8'h50, 8'h51);
    push(4'd7, 8'h07, 8'h00, 8'h7D, 8'h71);
    push(4'd6, 8'h06, 8'h00, 8'h6C, 8'h61);
    push(4'd13, 8'h0D, 8'h00, 8'hDE, 8'hD1);
    bus.fu_busy = 1'b1;
    dispatch(4'd5, 8'h05, 8'h00, 2'b11, 4'h0, 4'h0, 8'h50, 8'h51);
    dispatch(4'd6, 8'h06, 8'h00, 2'b10, 4'hC, 4'h0, 8'h00, 8'h61);
    bus.fu_busy = 1'b0;
    tick();
    check("age_first", 32'(bus.issue_robid), 32'd5);
    dispatch(4'd7, 8'h07, 8'h00, 2'b10, 4'hD, 4'h0, 8'h00, 8'h71);
    cdb(1'b1, 4'hD, 8'h7D);
    tick();
    cdb(1'b0, 4'h0, 8'h00);
    tick();
    check("age_younger_first_tx", 32'(bus.issue_transmit), 32'd1);
    check("age_younger_first", 32'(bus.issue_robid), 32'd7);
    bus.fu_busy = 1'b1;
    dispatch(4'd13, 8'h0D, 8'h00, 2'b10, 4'hE, 4'h0, 8'h00, 8'hD1);
    cdb(1'b1, 4'hE, 8'hDE);
    tick();
    cdb(1'b1, 4'hC, 8'h6C);
    tick();
    cdb(1'b0, 4'h0, 8'h00);
    bus.fu_busy = 1'b0;
    tick();
    check("age_oldest_wins", 32'(bus.issue_robid), 32'd6);
    drain(20);

    // Flush with three entries held, issue pending and a dispatch in flight
    bus.fu_busy = 1'b1;
    dispatch(4'd14, 8'h0E, 8'h00, 2'b11, 4'h0, 4'h0, 8'h01, 8'h02);
    dispatch(4'd15, 8'h0F, 8'h00, 2'b11, 4'h0, 4'h0, 8'h03, 8'h04);
    dispatch(4'd0,  8'h10, 8'h00, 2'b11, 4'h0, 4'h0, 8'h05, 8'h06);
    bus.fu_busy = 1'b0;
    bus.flush   = 1'b1;
    set_dispatch(4'd1, 8'h11, 8'h00, 2'b11, 4'h0, 4'h0, 8'h07, 8'h08);
    tick();
    bus.flush          = 1'b0;
    bus.dispatch_valid = 1'b0;
    check("flush_transmit", 32'(bus.issue_transmit), 32'd0);
    check("flush_rs_full", 32'(bus.rs_full), 32'd0);
    repeat (4) begin
      tick();
      check("flush_no_issue", 32'(bus.issue_transmit), 32'd0);
    end
    push(4'd2, 8'h12, 8'h00, 8'h09, 8'h0A);
    dispatch(4'd2, 8'h12, 8'h00, 2'b11, 4'h0, 4'h0, 8'h09, 8'h0A);
    drain(10);

    // Asynchronous reset in the middle of traffic
    push(4'd3, 8'h13, 8'h00, 8'h0B, 8'h0C);
    bus.fu_busy = 1'b1;
    dispatch(4'd3, 8'h13, 8'h00, 2'b11, 4'h0, 4'h0, 8'h0B, 8'h0C);
    dispatch(4'd4, 8'h14, 8'h00, 2'b11, 4'h0, 4'h0, 8'h0D, 8'h0E);
    bus.fu_busy = 1'b0;
    tick();
    check("rst_pre_issue", 32'(bus.issue_transmit), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      check("rst_discarded", 32'(bus.issue_transmit), 32'd0);
    end
    push(4'd5, 8'h15, 8'h00, 8'h0F, 8'h10);
    dispatch(4'd5, 8'h15, 8'h00, 2'b11, 4'h0, 4'h0, 8'h0F, 8'h10);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of reservation-station entries (2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  synchronous clear of all entries (mispredict).
REQ-005 SHALL have port: dispatch_valid  input  1  dispatch request this cycle.
REQ-006 SHALL have ports: dispatch_operand / dispatch_flags / dispatch_wbs  input  8 each  passed unchanged to the ALU FU.
REQ-007 SHALL have port: dispatch_robid  input  4  ROB tag of the instruction.
REQ-008 SHALL have port: dispatch_depready  input  2  per-source value already valid.
REQ-009 SHALL have port: dispatch_deptag  input  2x4  producer ROB tag per source.
REQ-010 SHALL have port: dispatch_depval  input  2x8  source value, meaningful when ready.
REQ-011 SHALL have port: rs_full  output  1  all entries occupied; dispatch refused.
REQ-012 SHALL have ports: cdb_valid  input  1; cdb_id  input  4; cdb_val  input  8  CDB broadcast snoop.
REQ-013 SHALL have port: fu_busy  input  1  ALU FU busy (stall).
REQ-014 SHALL have port: issue_transmit  output  1  registered one-cycle issue strobe.
REQ-015 SHALL have ports: issue_operand / issue_flags / issue_wbs  output  8 each; issue_depvals  output  2x8; issue_robid  output  4  registered payload, valid with issue_transmit.

Function
REQ-016 SHALL accept a dispatch at a rising edge when dispatch_valid=1, rs_full=0, flush=0, writing the lowest-index free entry.
REQ-017 SHALL ignore dispatch_valid while rs_full=1; rs_full is derived from current entry state only (an issue in the same cycle does not free space early).
REQ-018 SHALL treat source 1 as ready at dispatch when dispatch_flags[2]=1 (immediate form), regardless of dispatch_depready[1].
REQ-019 SHALL, for every valid entry source not ready, capture cdb_val and mark ready at the edge where cdb_valid=1 and cdb_id equals its tag.
REQ-020 SHALL apply REQ-019 to the dispatching instruction in the same cycle (dispatch/CDB bypass), so a matching broadcast is never lost.
REQ-021 SHALL mark an entry ready when valid and both sources ready.
REQ-022 SHALL issue at an edge when fu_busy=0, issue_transmit=0 and at least one entry is ready; otherwise no issue occurs (minimum one idle cycle between issues).
REQ-023 SHALL select the oldest ready entry by dispatch order, not by index.
REQ-024 SHALL, on issue, load the issue_* registers from the selected entry, set issue_transmit=1 for exactly one cycle, and free the entry at the same edge.
REQ-025 SHALL allow an entry dispatched or woken at edge E to issue no earlier than edge E+1 (issue_transmit high after E+1).
REQ-026 SHALL hold issue_* payload stable when issue_transmit=0 (last issued values).
REQ-027 SHALL, when flush=1 at an edge, invalidate all entries and clear issue_transmit; flush has priority over dispatch, wake-up and issue.
REQ-028 SHALL allow a freed entry to be re-dispatched at the following edge.

Reset
REQ-029 SHALL, on rst=1, asynchronously clear all entry valid bits and age state, drive rs_full=0, issue_transmit=0 and all issue_* payload outputs to 0.
REQ-030 SHALL, on reset mid-operation, discard all held instructions; no issue occurs until a new dispatch after rst deasserts.

Structure
REQ-031 SHALL take the entry record type (operand, flags, wbs, robid, deptag[2], depval[2], depready[2], valid) plus ROBID_W=4 and DATA_W=8 from the shared package alu_pkg.
REQ-032 SHALL implement oldest-ready selection in one sub-module, alu_rs_select (ready vector + age state in, one-hot grant out, combinational).

Verification
REQ-033 SHALL cover: dispatch ADD, both ready, vals 0x12/0x34, fu_busy=0 -> issue_transmit one cycle after the edge following dispatch, issue_depvals={0x12,0x34}, entry freed.
REQ-034 SHALL cover: dispatch with src0 tag 5 not ready; cdb_valid, id=5, val=0xA5 two cycles later -> issue_depvals[0]=0xA5, issue on next eligible edge.
REQ-035 SHALL cover: cdb id=3 val=0x7F in same cycle as dispatch of entry waiting on tag 3 -> value captured, entry issues without further broadcast.
REQ-036 SHALL cover: fill 4 entries with fu_busy=1 -> rs_full=1, fifth dispatch ignored; release fu_busy -> issues in dispatch order, one every second cycle.
REQ-037 SHALL cover: younger entry ready before older -> younger issues first; once both ready, oldest wins.
REQ-038 SHALL cover: flush with 3 entries valid and issue pending -> all cleared, issue_transmit=0, rs_full=0 next cycle; async rst mid-stream -> outputs 0 immediately.
